// File: rtl/ysyx_23060191_lsu.sv
// Load/store unit between EXU and WBU: one bus transaction per request, load align/extend.
// Optional misaligned-access fault check enabled by defining LSU_MISALIGN_CHECK_EN.
module ysyx_23060191_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mem_op,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] exu_res,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_rdata,
  input  logic              bus_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] lsu_res,
  output logic              load_en,
  output logic [DATA_W-1:0] exu_res_o,
  output logic              lsu_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, exu_q, res_q;
  logic                err_q;

  logic                legal, misalign, accept;
  logic [DATA_W-1:0]   shifted, load_data;
  logic [3:0]          wstrb_c;
  logic [DATA_W-1:0]   wdata_c;

  assign accept = (state_q == IDLE) && in_valid;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    legal = 1'b0;
    case (mem_op)
      OP_LOAD:  legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OP_STORE: legal = funct3 inside {3'b000, 3'b001, 3'b010};
      default:  legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (mem_op == OP_NONE)      state_d = DONE;
        else if (legal && !misalign) state_d = REQ;
        else                         state_d = DONE;
      end
      REQ:  if (bus_req_ready)  state_d = WAIT;
      WAIT: if (bus_resp_valid) state_d = DONE;
      DONE: if (out_ready)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bytes shifted past the top of the word read as zero before extension.
  assign shifted = bus_resp_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = shifted;
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << addr_q[1:0];
        wdata_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wstrb_c = 4'b0011 << {addr_q[1], 1'b0};
        wdata_c = {2{wdata_q[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = wdata_q;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      exu_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= mem_op;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
        exu_q   <= exu_res;
        res_q   <= '0;
        err_q   <= (mem_op != OP_NONE) && (!legal || misalign);
      end else if ((state_q == WAIT) && bus_resp_valid) begin
        err_q <= bus_resp_err;
        res_q <= (bus_resp_err || (op_q != OP_LOAD)) ? '0 : load_data;
      end
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign bus_req_valid = (state_q == REQ);
  assign bus_req_we    = (op_q == OP_STORE);
  assign bus_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_req_wdata = (op_q == OP_STORE) ? wdata_c : '0;
  assign bus_req_wstrb = (op_q == OP_STORE) ? wstrb_c : 4'b0000;
  assign out_valid     = (state_q == DONE);
  assign lsu_res       = res_q;
  assign load_en       = (op_q == OP_LOAD);
  assign exu_res_o     = exu_q;
  assign lsu_err       = err_q;

endmodule

// File: tb/tb_ysyx_23060191_lsu.sv
// Directed self-checking bench for ysyx_23060191_lsu (honours LSU_MISALIGN_CHECK_EN if defined).
module tb_ysyx_23060191_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  mem_op;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, exu_res;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid, bus_resp_err;
  logic [31:0] bus_resp_rdata;
  logic        out_valid, out_ready, load_en, lsu_err;
  logic [31:0] lsu_res, exu_res_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060191_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .funct3(funct3), .addr(addr), .wdata(wdata), .exu_res(exu_res),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .lsu_res(lsu_res), .load_en(load_en), .exu_res_o(exu_res_o), .lsu_err(lsu_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; returns one cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er);
    in_valid = 1'b1; mem_op = op; funct3 = f3; addr = a; wdata = wd; exu_res = er;
    step();
    in_valid = 1'b0;
  endtask

  // Complete a pending bus request with a one-cycle response; returns in DONE.
  task automatic bus_serve(input logic [31:0] rd, input logic er);
    bit seen = 0;
    bus_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus_req_valid) begin seen = 1; break; end
      step();
    end
    check("req_seen", {31'h0, seen}, 32'h1);
    step();
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_rdata = rd; bus_resp_err = er;
    step();
    bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
    issue(2'b01, f3, a, 32'h0, 32'h0);
    bus_serve(rd, 1'b0);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_res"}, lsu_res, exp);
    check({tag, "_load_en"}, {31'h0, load_en}, 32'h1);
    check({tag, "_err"}, {31'h0, lsu_err}, 32'h0);
    step();
  endtask

  task automatic store_req(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] exp_wd);
    check({tag, "_valid"}, {31'h0, bus_req_valid}, 32'h1);
    check({tag, "_we"}, {31'h0, bus_req_we}, 32'h1);
    check({tag, "_addr"}, bus_req_addr, {a[31:2], 2'b00});
    check({tag, "_wstrb"}, {28'h0, bus_req_wstrb}, {28'h0, strb});
    check({tag, "_wdata"}, bus_req_wdata, exp_wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mem_op = 2'b00; funct3 = 3'b000;
    addr = '0; wdata = '0; exu_res = '0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0; bus_resp_err = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_req_valid", {31'h0, bus_req_valid}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_lsu_res", lsu_res, 32'h0);
    check("rst_load_en", {31'h0, load_en}, 32'h0);
    check("rst_err", {31'h0, lsu_err}, 32'h0);
    check("rst_exu_res_o", exu_res_o, 32'h0);
    check("rst_wstrb", {28'h0, bus_req_wstrb}, 32'h0);
    rst_n = 1'b1;
    step();

    // Pass-through
    issue(2'b00, 3'b000, 32'h0, 32'h0, 32'h1234_5678);
    check("pt_valid", {31'h0, out_valid}, 32'h1);
    check("pt_exu", exu_res_o, 32'h1234_5678);
    check("pt_load_en", {31'h0, load_en}, 32'h0);
    check("pt_res", lsu_res, 32'h0);
    check("pt_no_req", {31'h0, bus_req_valid}, 32'h0);
    check("pt_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    check("pt_done", {31'h0, out_valid}, 32'h0);
    check("pt_idle", {31'h0, in_ready}, 32'h1);

    // LB request fields, then response
    issue(2'b01, 3'b000, 32'h8000_0003, 32'h0, 32'h0);
    check("lb_req_valid", {31'h0, bus_req_valid}, 32'h1);
    check("lb_req_addr", bus_req_addr, 32'h8000_0000);
    check("lb_req_wstrb", {28'h0, bus_req_wstrb}, 32'h0);
    check("lb_req_we", {31'h0, bus_req_we}, 32'h0);
    bus_serve(32'h80AA_BBCC, 1'b0);
    check("lb_res", lsu_res, 32'hFFFF_FF80);
    check("lb_load_en", {31'h0, load_en}, 32'h1);
    step();
    load_case("lbu", 3'b100, 32'h8000_0003, 32'h80AA_BBCC, 32'h0000_0080);
    load_case("lb1", 3'b000, 32'h8000_0001, 32'h80AA_BBCC, 32'hFFFF_FFBB);
    load_case("lh2", 3'b001, 32'h8000_0002, 32'h8001_0000, 32'hFFFF_8001);
    load_case("lhu2", 3'b101, 32'h8000_0002, 32'h8001_0000, 32'h0000_8001);
    load_case("lh0", 3'b001, 32'h8000_0000, 32'h0000_7FFE, 32'h0000_7FFE);
    load_case("lw", 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // SH with request backpressure
    issue(2'b10, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      store_req("sh", 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
      step();
    end
    store_req("sh", 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
    bus_serve(32'hFFFF_FFFF, 1'b0);
    check("sh_valid", {31'h0, out_valid}, 32'h1);
    check("sh_load_en", {31'h0, load_en}, 32'h0);
    check("sh_res", lsu_res, 32'h0);
    check("sh_err", {31'h0, lsu_err}, 32'h0);
    step();

    issue(2'b10, 3'b000, 32'h1000_0001, 32'h0000_00A5, 32'h0);
    store_req("sb", 3'b000, 32'h1000_0001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
    bus_serve(32'h0, 1'b0);
    step();
    issue(2'b10, 3'b010, 32'h1000_0008, 32'h0102_0304, 32'h0);
    store_req("sw", 3'b010, 32'h1000_0008, 32'h0102_0304, 4'b1111, 32'h0102_0304);
    bus_serve(32'h0, 1'b0);
    step();

    // LW with bus error under output backpressure
    out_ready = 1'b0;
    issue(2'b01, 3'b010, 32'h8000_0004, 32'h0, 32'h5555_AAAA);
    bus_serve(32'h1122_3344, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("berr_valid", {31'h0, out_valid}, 32'h1);
      check("berr_err", {31'h0, lsu_err}, 32'h1);
      check("berr_res", lsu_res, 32'h0);
      check("berr_load_en", {31'h0, load_en}, 32'h1);
      check("berr_exu", exu_res_o, 32'h5555_AAAA);
      check("berr_in_ready", {31'h0, in_ready}, 32'h0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("berr_done", {31'h0, out_valid}, 32'h0);
    check("berr_idle", {31'h0, in_ready}, 32'h1);

    // Illegal encodings fault without a bus transaction
    issue(2'b01, 3'b011, 32'h0, 32'h0, 32'h0);
    check("ill_ld_req", {31'h0, bus_req_valid}, 32'h0);
    check("ill_ld_err", {31'h0, lsu_err}, 32'h1);
    check("ill_ld_load_en", {31'h0, load_en}, 32'h1);
    check("ill_ld_valid", {31'h0, out_valid}, 32'h1);
    step();
    issue(2'b10, 3'b100, 32'h0, 32'h0, 32'h0);
    check("ill_st_err", {31'h0, lsu_err}, 32'h1);
    check("ill_st_load_en", {31'h0, load_en}, 32'h0);
    step();
    issue(2'b11, 3'b000, 32'h0, 32'h0, 32'h0);
    check("op11_err", {31'h0, lsu_err}, 32'h1);
    check("op11_valid", {31'h0, out_valid}, 32'h1);
    step();

    // Reset while waiting for a response
    issue(2'b01, 3'b010, 32'h8000_0010, 32'h0, 32'h0);
    check("rmid_req", {31'h0, bus_req_valid}, 32'h1);
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    check("rmid_in_ready_wait", {31'h0, in_ready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_req_valid", {31'h0, bus_req_valid}, 32'h0);
    check("rmid_out_valid", {31'h0, out_valid}, 32'h0);
    check("rmid_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    rst_n = 1'b1;
    bus_resp_valid = 1'b1; bus_resp_rdata = 32'hFFFF_FFFF;
    step();
    bus_resp_valid = 1'b0;
    check("late_resp_valid", {31'h0, out_valid}, 32'h0);
    check("late_resp_idle", {31'h0, in_ready}, 32'h1);
    check("late_resp_res", lsu_res, 32'h0);

    // Misaligned LW
    issue(2'b01, 3'b010, 32'h8000_0002, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_no_req", {31'h0, bus_req_valid}, 32'h0);
    check("mis_valid", {31'h0, out_valid}, 32'h1);
    check("mis_err", {31'h0, lsu_err}, 32'h1);
    check("mis_res", lsu_res, 32'h0);
`else
    check("mis_req", {31'h0, bus_req_valid}, 32'h1);
    check("mis_addr", bus_req_addr, 32'h8000_0000);
    bus_serve(32'hCAFE_F00D, 1'b0);
    check("mis_res", lsu_res, 32'h0000_CAFE);
    check("mis_err", {31'h0, lsu_err}, 32'h0);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060191_lsu.md
Name: ysyx_23060191_lsu

Overview:
- Load/store unit between EXU and WBU.
- Takes one memory-op request from EXU, runs one transaction on a simple valid/ready data bus, and aligns/extends load data.
- Presents lsu_res, load_en and the forwarded exu_res to the write-back stage through a valid/ready output.
- One outstanding operation at a time; no buffering beyond one entry.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, so byte lanes = 4.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EXU request valid
- in_ready  out  1  LSU can accept a request
- mem_op  in  2  00 none (pass-through), 01 load, 10 store, 11 reserved
- funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_W  effective address from EXU
- wdata  in  DATA_W  store data (rs2)
- exu_res  in  DATA_W  EXU result, forwarded unchanged
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_req_we  out  1  1 = write
- bus_req_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- bus_req_wdata  out  DATA_W  lane-replicated store data
- bus_req_wstrb  out  4  byte strobes (0 for loads)
- bus_resp_valid  in  1  response valid, single-cycle pulse
- bus_resp_rdata  in  DATA_W  read word
- bus_resp_err  in  1  bus error
- out_valid  out  1  result valid to WBU
- out_ready  in  1  WBU accepts result
- lsu_res  out  DATA_W  aligned and extended load data
- load_en  out  1  1 = WBU selects lsu_res
- exu_res_o  out  DATA_W  latched exu_res
- lsu_err  out  1  access fault for this op

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (async, rst_n=0): state goes to IDLE immediately. All outputs are 0 except in_ready=1. Any in-flight transaction is abandoned, and bus_req_valid drops combinationally with reset.
- IDLE:
  - in_ready=1. On in_valid, latch mem_op, funct3, addr, wdata, exu_res.
  - mem_op 00 → DONE.
  - mem_op 01/10 with legal funct3 → REQ.
  - mem_op 11, or illegal funct3 → DONE with lsu_err=1. Illegal funct3 for a load is 011/110/111; illegal for a store is anything other than 000/001/010.
- REQ: bus_req_valid=1, all bus fields stable until bus_req_ready. On handshake → WAIT.
- WAIT: sample bus_resp_valid only in this state; a response in the REQ handshake cycle is a bus protocol violation. On response → DONE, capturing the result.
- DONE: out_valid=1 and outputs held stable until out_ready; then → IDLE. in_ready=0 in REQ/WAIT/DONE, so there is no accept in the same cycle DONE exits.
- Latency:
  - Pass-through: out_valid asserts the cycle after accept.
  - Memory op: minimum 3 cycles from accept to out_valid (REQ ready immediately, response the following cycle).
- Store encoding:
  - wstrb: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<{addr[1],1'b0}, truncated to 4 bits; SW = 4'b1111.
  - wdata: SB replicates byte ×4; SH replicates half ×2; SW unchanged.
- Load decode:
  - Shift rdata right by addr[1:0]*8.
  - B/H sign-extend; BU/HU zero-extend; W unchanged.
- Outputs for non-load ops: stores and pass-through give load_en=0, lsu_res=0.
- Loads: load_en=1, including when lsu_err=1.
- Bus error: bus_resp_err=1 gives lsu_err=1 and lsu_res=0; load_en follows op type.
- Output stability: outputs stay stable in DONE under out_ready backpressure of any length.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: an H/HU access with addr[0]=1, or a W access with addr[1:0]≠0, issues no bus transaction. It goes IDLE → DONE with lsu_err=1 and lsu_res=0.
- Undefined: no check. Misaligned accesses issue normally; shifted-out bytes read as 0 before extension, and strobes are truncated to 4 bits.

Test Plan:
- Pass-through: mem_op=00, exu_res=0x1234_5678, out_ready=1 → out_valid the next cycle; exu_res_o=0x12345678, load_en=0, no bus_req_valid.
- LB sign-extend: addr=0x8000_0003, rdata=0x80AA_BBCC → bus_req_addr=0x80000000, wstrb=0, lsu_res=0xFFFF_FF80, load_en=1; LBU same → 0x0000_0080.
- SH: addr=0x8000_0002, wdata=0xDEAD_BEEF → bus_req_we=1, wstrb=4'b1100, bus_req_wdata=0xBEEF_BEEF; bus_req_ready held 0 for 5 cycles → request fields stable throughout.
- Backpressure plus error: LW with bus_resp_err=1 and out_ready=0 for 4 cycles → lsu_err=1, lsu_res=0, out_valid held; in_ready=0 until the output handshake.
- Reset mid-op: rst_n low while in WAIT → bus_req_valid=0, out_valid=0, in_ready=1 asynchronously; a late bus_resp_valid after reset release is ignored in IDLE.
- LW at addr=0x8000_0002: with LSU_MISALIGN_CHECK_EN → no bus request, lsu_err=1; without → bus request issued, lsu_res=rdata>>16.
